// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants, word-map indices and the receive descriptor type
// used by the ARP receive parser and its statistics block.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OPER_REP   = 16'h0002;
    localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
    localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;
    localparam logic [47:0] MAC_BCAST      = 48'hFFFF_FFFF_FFFF;

    localparam int unsigned STATS_W = 16;

    // Index of each 32-bit word within the frame
    localparam logic [3:0] W_DST_HI  = 4'd0;
    localparam logic [3:0] W_DST_LO  = 4'd1;
    localparam logic [3:0] W_ETYPE   = 4'd3;
    localparam logic [3:0] W_PTYPE   = 4'd4;
    localparam logic [3:0] W_OPER    = 4'd5;
    localparam logic [3:0] W_SHA_LO  = 4'd6;
    localparam logic [3:0] W_SPA     = 4'd7;
    localparam logic [3:0] W_TPA_HI  = 4'd9;
    localparam logic [3:0] W_TPA_LO  = 4'd10;
    localparam logic [3:0] W_CNT_MAX = 4'd15;

    typedef struct packed {
        logic        oper;
        logic [47:0] sha;
        logic [31:0] spa;
    } arp_desc_t;

endpackage

// File: rtl/arp_rx_stats.sv
// Wrapping good/drop frame counters for the ARP receive parser.
module arp_rx_stats
    import eth_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ok_evt_i,
    input  logic               drop_evt_i,
    output logic [STATS_W-1:0] rx_ok_cnt_o,
    output logic [STATS_W-1:0] rx_drop_cnt_o
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_ok_cnt_o   <= '0;
            rx_drop_cnt_o <= '0;
        end else begin
            if (ok_evt_i)   rx_ok_cnt_o   <= rx_ok_cnt_o + 1'b1;
            if (drop_evt_i) rx_drop_cnt_o <= rx_drop_cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/arp_rx_parser.sv
// Parses 32-bit Ethernet/ARP frames into a one-deep request/reply descriptor.
// Define ARP_RX_STATS_EN to add the rx_ok_cnt_o / rx_drop_cnt_o statistics ports.
module arp_rx_parser
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] s_tdata_i,
    input  logic        s_tvld_i,
    input  logic        s_tlast_i,
    input  logic [3:0]  s_tkeep_i,
    output logic        s_trdy_o,
    input  logic [47:0] local_mac_i,
    input  logic [31:0] local_ip_i,
    output logic        arp_vld_o,
    output logic        arp_oper_o,
    output logic [47:0] arp_sha_o,
    output logic [31:0] arp_spa_o,
    input  logic        arp_rdy_i
`ifdef ARP_RX_STATS_EN
    ,
    output logic [15:0] rx_ok_cnt_o,
    output logic [15:0] rx_drop_cnt_o
`endif
);

    localparam logic [0:0] ST_PARSE = 1'b0;
    localparam logic [0:0] ST_DROP  = 1'b1;

    logic       trdy_q;
    logic [0:0] state_q;
    logic [3:0] wcnt_q;
    logic       bad_q;
    logic       dst_bc_q;
    logic       dst_loc_q;
    arp_desc_t  cap_q;
    arp_desc_t  desc_q;
    logic       vld_q;

    logic       beat;
    logic       chk_fail;
    logic       bad_now;
    logic       len_ok;
    logic       good_frame;
    logic       load;
    logic       keep_unused;

    assign keep_unused = ^s_tkeep_i[1:0];

    assign beat       = s_tvld_i & trdy_q;
    assign bad_now    = bad_q | chk_fail;
    assign len_ok     = (wcnt_q > W_TPA_LO) ||
                        ((wcnt_q == W_TPA_LO) && (s_tkeep_i[3:2] == 2'b11));
    assign good_frame = beat & s_tlast_i & ~bad_now & len_ok;
    assign load       = good_frame & (~vld_q | arp_rdy_i);

    always_comb begin
        chk_fail = 1'b0;
        if (beat && (state_q == ST_PARSE)) begin
            case (wcnt_q)
                // The destination compare spans w0/w1; w0 only records partial matches
                W_DST_LO: chk_fail = !((dst_bc_q  && (s_tdata_i[31:16] == MAC_BCAST[15:0])) ||
                                       (dst_loc_q && (s_tdata_i[31:16] == local_mac_i[15:0])));
                W_ETYPE:  chk_fail = (s_tdata_i[31:16] != ETH_TYPE_ARP) ||
                                     (s_tdata_i[15:0]  != ARP_HTYPE_ETH);
                W_PTYPE:  chk_fail = (s_tdata_i[31:16] != ARP_PTYPE_IPV4) ||
                                     (s_tdata_i[15:8]  != ARP_HLEN_ETH)   ||
                                     (s_tdata_i[7:0]   != ARP_PLEN_IPV4);
                W_OPER:   chk_fail = (s_tdata_i[31:16] != ARP_OPER_REQ) &&
                                     (s_tdata_i[31:16] != ARP_OPER_REP);
                W_TPA_HI: chk_fail = (s_tdata_i[15:0]  != local_ip_i[31:16]);
                W_TPA_LO: chk_fail = (s_tdata_i[31:16] != local_ip_i[15:0]);
                default:  chk_fail = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trdy_q    <= 1'b0;
            state_q   <= ST_PARSE;
            wcnt_q    <= '0;
            bad_q     <= 1'b0;
            dst_bc_q  <= 1'b0;
            dst_loc_q <= 1'b0;
            cap_q     <= '0;
        end else begin
            trdy_q <= 1'b1;
            if (beat) begin
                if (s_tlast_i) begin
                    wcnt_q  <= '0;
                    bad_q   <= 1'b0;
                    state_q <= ST_PARSE;
                end else begin
                    if (wcnt_q != W_CNT_MAX) wcnt_q <= wcnt_q + 4'd1;
                    if (bad_now) begin
                        bad_q   <= 1'b1;
                        state_q <= ST_DROP;
                    end
                end

                case (wcnt_q)
                    W_DST_HI: begin
                        dst_bc_q  <= (s_tdata_i == MAC_BCAST[47:16]);
                        dst_loc_q <= (s_tdata_i == local_mac_i[47:16]);
                    end
                    W_OPER: begin
                        cap_q.oper       <= (s_tdata_i[31:16] == ARP_OPER_REQ);
                        cap_q.sha[47:32] <= s_tdata_i[15:0];
                    end
                    W_SHA_LO: cap_q.sha[31:0] <= s_tdata_i;
                    W_SPA:    cap_q.spa       <= s_tdata_i;
                    default: ;
                endcase
            end
        end
    end

    // A held descriptor wins over a new good frame unless it is consumed this cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= 1'b0;
            desc_q <= '0;
        end else if (load) begin
            vld_q  <= 1'b1;
            desc_q <= cap_q;
        end else if (arp_rdy_i) begin
            vld_q  <= 1'b0;
        end
    end

    assign s_trdy_o   = trdy_q;
    assign arp_vld_o  = vld_q;
    assign arp_oper_o = desc_q.oper;
    assign arp_sha_o  = desc_q.sha;
    assign arp_spa_o  = desc_q.spa;

`ifdef ARP_RX_STATS_EN
    logic drop_evt;

    assign drop_evt = (beat & s_tlast_i & ~good_frame) | (good_frame & vld_q & ~arp_rdy_i);

    arp_rx_stats u_stats (
        .clk           (clk),
        .reset_n       (reset_n),
        .ok_evt_i      (load),
        .drop_evt_i    (drop_evt),
        .rx_ok_cnt_o   (rx_ok_cnt_o),
        .rx_drop_cnt_o (rx_drop_cnt_o)
    );
`endif

endmodule

// File: tb/tb_arp_rx_parser.sv
// Randomized scoreboard bench for arp_rx_parser: frames are built as byte arrays
// and judged by a byte-offset reference model; a monitor checks every descriptor.
module tb_arp_rx_parser;
    import eth_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] s_tdata_i;
    logic        s_tvld_i;
    logic        s_tlast_i;
    logic [3:0]  s_tkeep_i;
    logic        s_trdy_o;
    logic [47:0] local_mac_i;
    logic [31:0] local_ip_i;
    logic        arp_vld_o;
    logic        arp_oper_o;
    logic [47:0] arp_sha_o;
    logic [31:0] arp_spa_o;
    logic        arp_rdy_i;
`ifdef ARP_RX_STATS_EN
    logic [15:0] rx_ok_cnt_o;
    logic [15:0] rx_drop_cnt_o;
`endif

    always #5 clk = ~clk;

    arp_rx_parser dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_tdata_i   (s_tdata_i),
        .s_tvld_i    (s_tvld_i),
        .s_tlast_i   (s_tlast_i),
        .s_tkeep_i   (s_tkeep_i),
        .s_trdy_o    (s_trdy_o),
        .local_mac_i (local_mac_i),
        .local_ip_i  (local_ip_i),
        .arp_vld_o   (arp_vld_o),
        .arp_oper_o  (arp_oper_o),
        .arp_sha_o   (arp_sha_o),
        .arp_spa_o   (arp_spa_o),
        .arp_rdy_i   (arp_rdy_i)
`ifdef ARP_RX_STATS_EN
        ,
        .rx_ok_cnt_o   (rx_ok_cnt_o),
        .rx_drop_cnt_o (rx_drop_cnt_o)
`endif
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Big-endian field of len bytes starting at byte offset off
    function automatic logic [47:0] fld(input logic [7:0] f[$], input int off, input int len);
        logic [47:0] v = '0;
        for (int i = 0; i < len; i++) v = {v[39:0], f[off+i]};
        return v;
    endfunction

    function automatic bit ref_good(input logic [7:0] f[$]);
        logic [47:0] dst;
        if (f.size() < 42) return 1'b0;
        dst = fld(f, 0, 6);
        if (dst != 48'hFFFF_FFFF_FFFF && dst != local_mac_i) return 1'b0;
        if (fld(f, 12, 2) != 48'h0806) return 1'b0;
        if (fld(f, 14, 2) != 48'h0001) return 1'b0;
        if (fld(f, 16, 2) != 48'h0800) return 1'b0;
        if (f[18] != 8'd6 || f[19] != 8'd4) return 1'b0;
        if (fld(f, 20, 2) != 48'd1 && fld(f, 20, 2) != 48'd2) return 1'b0;
        if (fld(f, 38, 4) != {16'h0, local_ip_i}) return 1'b0;
        return 1'b1;
    endfunction

    function automatic arp_desc_t ref_desc(input logic [7:0] f[$]);
        arp_desc_t d;
        d.oper = (fld(f, 20, 2) == 48'd1);
        d.sha  = fld(f, 22, 6);
        d.spa  = fld(f, 28, 4)[31:0];
        return d;
    endfunction

    function automatic void build(output logic [7:0] f[$], input int dk, input logic [15:0] et,
                                  input logic [15:0] op, input logic [47:0] sha,
                                  input logic [31:0] spa, input logic [31:0] tpa, input int n);
        logic [47:0]  dst;
        logic [335:0] h;
        case (dk)
            0:       dst = 48'hFFFF_FFFF_FFFF;
            1:       dst = local_mac_i;
            default: dst = {16'h0A00, 32'($urandom())};
        endcase
        h = {dst, 16'h0200, 32'($urandom()), et, 16'h0001, 16'h0800, 8'd6, 8'd4, op, sha, spa,
             16'h0000, 32'($urandom()), tpa};
        f.delete();
        for (int i = 0; i < n; i++)
            f.push_back(i < 42 ? h[335-8*i -: 8] : 8'($urandom()));
    endfunction

    // Stimulus-side tag describing the beat currently on the bus
    logic      tb_good;
    arp_desc_t tb_desc;
    int        rdy_mode;
    bit        gap_en;

    arp_desc_t   exp_q[$];
    bit          m_vld;
    int unsigned m_ok, m_drop, rst_age;

    // Reference output register: one descriptor slot, refilled only when empty or being consumed
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_vld   = 1'b0;
            m_ok    = 0;
            m_drop  = 0;
            rst_age = 0;
            exp_q.delete();
        end else begin
            rst_age++;
            if (s_tvld_i && s_tlast_i && tb_good && (!m_vld || arp_rdy_i)) begin
                exp_q.push_back(tb_desc);
                m_vld = 1'b1;
                m_ok++;
            end else begin
                if (s_tvld_i && s_tlast_i) m_drop++;
                if (arp_rdy_i) m_vld = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_trdy", 64'(s_trdy_o), 64'd0);
            chk("rst_vld",  64'(arp_vld_o), 64'd0);
            chk("rst_desc", {arp_oper_o, arp_sha_o}, 64'd0);
            chk("rst_spa",  64'(arp_spa_o), 64'd0);
        end else begin
            if (rst_age >= 1) chk("trdy", 64'(s_trdy_o), 64'd1);
            chk("vld", 64'(arp_vld_o), 64'(m_vld));
            if (arp_vld_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_desc", 64'(arp_vld_o), 64'd0);
                end else begin
                    chk("oper", 64'(arp_oper_o), 64'(exp_q[0].oper));
                    chk("sha",  64'(arp_sha_o),  64'(exp_q[0].sha));
                    chk("spa",  64'(arp_spa_o),  64'(exp_q[0].spa));
                    if (arp_rdy_i) void'(exp_q.pop_front());
                end
            end
`ifdef ARP_RX_STATS_EN
            chk("ok_cnt",   64'(rx_ok_cnt_o),   64'(m_ok[15:0]));
            chk("drop_cnt", 64'(rx_drop_cnt_o), 64'(m_drop[15:0]));
`endif
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       arp_rdy_i = ($urandom_range(0, 2) == 0);
                1:       arp_rdy_i = 1'b0;
                default: arp_rdy_i = 1'b1;
            endcase
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            s_tvld_i  = 1'b0;
            s_tlast_i = 1'b0;
            s_tdata_i = $urandom();
            tb_good   = 1'b0;
        end
    endtask

    // abort_at >= 0 asserts reset in place of that word and abandons the frame
    task automatic send(input logic [7:0] f[$], input int abort_at);
        int nw = (f.size() + 3) / 4;
        int rem;
        for (int w = 0; w < nw; w++) begin
            if (gap_en && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            @(posedge clk);
            #1;
            if (w == abort_at) begin
                reset_n  = 1'b0;
                s_tvld_i = 1'b0;
                tb_good  = 1'b0;
                return;
            end
            for (int b = 0; b < 4; b++)
                s_tdata_i[31-8*b -: 8] = (4*w + b < f.size()) ? f[4*w+b] : 8'h00;
            s_tvld_i  = 1'b1;
            s_tlast_i = (w == nw - 1);
            rem       = f.size() - 4*w;
            s_tkeep_i = s_tlast_i ? ~(4'b1111 >> rem) : 4'($urandom());
            tb_good   = s_tlast_i && ref_good(f);
            tb_desc   = ref_desc(f);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, %0d vectors", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  f[$];
        int          dk, n, o;
        logic [15:0] op;

        reset_n     = 1'b0;
        s_tvld_i    = 1'b0;
        s_tlast_i   = 1'b0;
        s_tkeep_i   = 4'hF;
        s_tdata_i   = '0;
        tb_good     = 1'b0;
        tb_desc     = '0;
        arp_rdy_i   = 1'b1;
        rdy_mode    = 2;
        gap_en      = 1'b0;
        local_mac_i = 48'h02AA_BBCC_DDEE;
        local_ip_i  = 32'hC0A8_0101;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(3);

        // Broadcast request, 60 bytes
        build(f, 0, 16'h0806, 16'h0001, 48'h0200_0000_0001, 32'hC0A8_010A, local_ip_i, 60);
        send(f, -1);
        idle(3);
        // Wrong target IP
        build(f, 0, 16'h0806, 16'h0001, 48'h0200_0000_0001, 32'hC0A8_010A, local_ip_i + 1, 60);
        send(f, -1);
        idle(3);
        // Held descriptor, then a unicast reply overflows
        rdy_mode = 1;
        build(f, 0, 16'h0806, 16'h0001, 48'h0200_0000_0002, 32'hC0A8_0114, local_ip_i, 60);
        send(f, -1);
        idle(2);
        build(f, 1, 16'h0806, 16'h0002, 48'h0200_0000_0003, 32'hC0A8_011E, local_ip_i, 60);
        send(f, -1);
        idle(4);
        rdy_mode = 2;
        idle(2);
        // tlast at w7, then a good frame back-to-back
        build(f, 0, 16'h0806, 16'h0001, 48'h0200_0000_0004, 32'hC0A8_0128, local_ip_i, 32);
        send(f, -1);
        build(f, 1, 16'h0806, 16'h0002, 48'h0200_0000_0005, 32'hC0A8_0132, local_ip_i, 60);
        send(f, -1);
        // IPv4 ethertype, then ARP back-to-back
        build(f, 0, 16'h0800, 16'h0001, 48'h0200_0000_0006, 32'hC0A8_013C, local_ip_i, 60);
        send(f, -1);
        build(f, 0, 16'h0806, 16'h0001, 48'h0200_0000_0007, 32'hC0A8_0146, local_ip_i, 60);
        send(f, -1);
        idle(2);
        // Length boundaries: 42 bytes is the minimum accepted
        for (int len = 40; len <= 43; len++) begin
            build(f, 0, 16'h0806, 16'h0001, {40'h02_0000_0100, 8'(len)}, 32'hC0A8_0200, local_ip_i, len);
            send(f, -1);
        end
        idle(2);
        // Reset at w5 abandons the frame
        build(f, 0, 16'h0806, 16'h0001, 48'h0200_0000_0008, 32'hC0A8_0150, local_ip_i, 60);
        send(f, 5);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(3);
        build(f, 1, 16'h0806, 16'h0001, 48'h0200_0000_0009, 32'hC0A8_015A, local_ip_i, 60);
        send(f, -1);
        idle(3);

        rdy_mode = 0;
        gap_en   = 1'b1;
        for (int k = 0; k < 200; k++) begin
            dk = $urandom_range(0, 5);
            dk = (dk <= 2) ? 0 : (dk <= 4) ? 1 : 2;
            op = ($urandom_range(0, 1) == 0) ? 16'h0001 : 16'h0002;
            n  = $urandom_range(38, 70);
            build(f, dk, 16'h0806, op, {16'h0200, 32'($urandom())}, $urandom(), local_ip_i, n);
            if ($urandom_range(0, 2) == 0) begin
                o = $urandom_range(0, 41);
                if (o < n) f[o] = f[o] ^ 8'($urandom_range(1, 255));
            end
            send(f, -1);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end

        rdy_mode = 2;
        idle(6);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arp_rx_parser.md
ARP_RX_PARSER -- requirements
Module: arp_rx_parser

Interface
REQ-001 The block SHALL have no parameters; all constants come from the shared package.
REQ-002 clk  in  1  single clock, all logic rising-edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 s_tdata_i  in  32  frame word; first byte of the word in [31:24].
REQ-005 s_tvld_i  in  1  word valid.
REQ-006 s_tlast_i  in  1  last word of frame.
REQ-007 s_tkeep_i  in  4  byte enables; [3] maps to [31:24]; ignored except on the last word.
REQ-008 s_trdy_o  out  1  ready; tied 1 outside reset.
REQ-009 local_mac_i  in  48  station MAC, quasi-static.
REQ-010 local_ip_i  in  32  station IPv4, quasi-static.
REQ-011 arp_vld_o  out  1  descriptor valid.
REQ-012 arp_oper_o  out  1  1 = request, 0 = reply.
REQ-013 arp_sha_o  out  48  sender MAC.
REQ-014 arp_spa_o  out  32  sender IP.
REQ-015 arp_rdy_i  in  1  descriptor consumed when arp_vld_o & arp_rdy_i.

Function
REQ-016 A beat SHALL be accepted when s_tvld_i & s_trdy_o.
REQ-017 A 4-bit word counter SHALL count accepted beats from 0 per frame, saturate at 15, and clear after the tlast beat.
REQ-018 Word map SHALL be: w0 dst[0:3]; w1 dst[4:5],src[0:1]; w3 ethertype,htype; w4 ptype,hlen,plen; w5 oper,sha[0:1]; w6 sha[2:5]; w7 spa; w9[15:0] tpa[0:1]; w10[31:16] tpa[2:3].
REQ-019 Checks SHALL be: dst = FF:FF:FF:FF:FF:FF or local_mac_i; ethertype 0x0806; htype 0x0001; ptype 0x0800; hlen 6; plen 4; oper 1 or 2; tpa = local_ip_i.
REQ-020 A sticky bad flag SHALL set on any failed check and clear at frame start.
REQ-021 The FSM SHALL have states PARSE (collecting words) and DROP (bad flag set; discard until tlast); the tlast beat returns to PARSE.
REQ-022 tlast at word count < 10 SHALL be a short frame and be dropped.
REQ-023 A frame SHALL be good if, on its tlast beat, bad = 0 and count >= 10 (tlast at word 10 requires s_tkeep_i[3:2] = 2'b11).
REQ-024 A good frame SHALL load the output register so arp_vld_o rises the cycle after the tlast beat (latency 1).
REQ-025 arp_vld_o SHALL hold with stable fields until arp_rdy_i.
REQ-026 Good frame while arp_vld_o=1 and arp_rdy_i=0: the new descriptor SHALL be discarded (overflow) and the old one kept.
REQ-027 Good frame in the same cycle as arp_vld_o & arp_rdy_i: the new descriptor SHALL load and arp_vld_o stays 1.
REQ-028 Frames SHALL be processed back-to-back with no idle cycles required between tlast and the next first word.

Reset
REQ-029 On reset_n=0: s_trdy_o=0, arp_vld_o=0, arp_oper_o=0, arp_sha_o=0, arp_spa_o=0, counter=0, bad=0, FSM=PARSE.
REQ-030 Reset mid-frame SHALL abandon the frame; after release the next word is treated as w0.

Configuration
REQ-031 With ARP_RX_STATS_EN defined, ports rx_ok_cnt_o[15:0] (good frames loaded) and rx_drop_cnt_o[15:0] (bad, short, overflow) SHALL exist, reset to 0 and wrap at 16 bits.
REQ-032 Without ARP_RX_STATS_EN, those ports and their counters SHALL be absent; all other behaviour is identical.

Structure
REQ-033 The shared package eth_pkg SHALL hold ETH_TYPE_ARP, ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_OPER_REQ/REP, MAC_BCAST and the arp_desc_t struct (oper, sha, spa).
REQ-034 Statistics SHALL be in one sub-module, arp_rx_stats, instantiated only under ARP_RX_STATS_EN.

Verification
REQ-035 Broadcast request, sha 02:00:00:00:00:01, spa 192.168.1.10, tpa = local_ip_i, 60-byte frame -> one cycle after tlast: arp_vld_o=1, oper=1, sha and spa matching.
REQ-036 Same frame with tpa = local_ip_i+1 -> no arp_vld_o; rx_drop_cnt_o increments by 1.
REQ-037 Reply unicast to local_mac_i while arp_rdy_i=0 holds the prior descriptor -> prior descriptor unchanged; rx_drop_cnt_o +1.
REQ-038 tlast at w7 -> dropped; the next valid frame, sent back-to-back, is parsed correctly.
REQ-039 ethertype 0x0800 frame followed immediately by a valid ARP request -> exactly one descriptor, for the ARP frame.
REQ-040 reset_n asserted at w5, released, then a valid frame -> exactly one correct descriptor and no stale data.
